nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs WORDS×4-bit additions by time-multiplexing one internal `fulladder4` nibble adder, least significant nibble first. It accepts operands over a valid/ready request channel and iterates one nibble per clock through the shared adder, carrying between nibbles in a register. It returns the result over a valid/ready response channel. It is the area-cheap alternative to chaining WORDS `fulladder4` instances.

## Interface
- `WORDS`, 4, number of nibbles per operand. Data width is W = 4*WORDS. Legal range is 1..16.
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req_valid_i` input 1: request operands valid.
- `req_ready_o` output 1: block can accept a request.
- `a_i` input W: operand A.
- `b_i` input W: operand B.
- `carry_i` input 1: carry-in to nibble 0. Ignored when `sub_i`=1.
- `sub_i` input 1: 1 selects A−B. Present only when `ADDER_SUB_EN` is defined.
- `rsp_valid_o` output 1: result valid.
- `rsp_ready_i` input 1: consumer accepts result.
- `sum_o` output W: result.
- `carry_o` output 1: final carry-out. In subtract mode, 0 means borrow.
- `busy_o` output 1: high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`&&`req_ready_o`: latch `a_i` into the A register.
  - Latch `b_i` into the B register, inverted if `sub_i`=1.
  - Load the carry register with `carry_i`, or 1 if `sub_i`=1.
  - Clear nibble index `idx`=0 and go to RUN.
- **RUN**
  - Each cycle, feed A[idx], B[idx] and the carry register to the shared `fulladder4`.
  - Write its `sum_o` into result nibble idx and its `carry_o` into the carry register, then increment `idx`.
  - When `idx`==WORDS−1 is processed, go to DONE.
  - `req_ready_o`=0.
- **DONE**
  - `rsp_valid_o`=1, `sum_o` = result register, `carry_o` = carry register.
  - Hold all outputs stable until `rsp_ready_i`=1.
  - On handshake, go to IDLE.
  - `req_ready_o`=0. A request cannot be accepted in the same cycle as the response handshake.
- Arithmetic is modulo 2^W. `carry_o` is bit W of A+B+cin, or of A+~B+1 in subtract mode. No overflow flag.
- Exactly one `fulladder4` instance exists. No other adder logic is permitted in the datapath.
- `idx` width is max(1, $clog2(WORDS)). It never counts past WORDS−1.
- WORDS=1 boundary: RUN lasts exactly one cycle.
- Request inputs are sampled only at the accepting edge. Changes afterwards have no effect.
- `rsp_ready_i` is ignored outside DONE.

## Timing
- Reset values: `req_ready_o`=1 (IDLE), `rsp_valid_o`=0, `sum_o`=0, `carry_o`=0, `busy_o`=0. All internal registers are 0.
- `rst_ni` low at any time, including mid-RUN or in DONE:
  - Immediately force IDLE and clear the registers.
  - The in-flight operation is discarded and no response is produced.
- Latency: request accepted at edge T. `rsp_valid_o` rises after edge T+WORDS.
- Minimum op-to-op period is WORDS+2 cycles, with `rsp_ready_i` held 1 and a request ready immediately.
- `sum_o`/`carry_o` are registered outputs. They are valid only while `rsp_valid_o`=1; other values are don't-care for checking.
- `busy_o` = (state != IDLE), driven combinationally from the state register.

## Configuration
- `ADDER_SUB_EN` defined:
  - The `sub_i` port exists.
  - `sub_i`=1 inverts B and forces carry-in to 1, computing A−B (two's complement). `carry_o`=0 indicates borrow.
- `ADDER_SUB_EN` undefined:
  - No `sub_i` port and no B inversion logic.
  - The block always computes A+B+`carry_i`.

## Test plan
- WORDS=4, A=0xFFFF, B=0x0001, cin=0 -> `sum_o`=0x0000, `carry_o`=1, `rsp_valid_o` rises 4 cycles after accept.
- WORDS=4, A=0x1234, B=0x4321, cin=1 -> `sum_o`=0x5556, `carry_o`=0. `req_ready_o`=0 throughout RUN/DONE.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles in DONE -> `rsp_valid_o`, `sum_o`, `carry_o` stable. A second `req_valid_i` is not accepted until the cycle after the handshake.
- `ADDER_SUB_EN`, A=0x0005, B=0x0007, `sub_i`=1 -> `sum_o`=0xFFFE, `carry_o`=0. A=0x0007, B=0x0005 -> 0x0002, `carry_o`=1.
- Assert `rst_ni`=0 two cycles into RUN -> outputs immediately return to reset values. No response appears after release. The next request completes correctly.
- WORDS=1, A=0xF, B=0x1, cin=0 -> `sum_o`=0x0, `carry_o`=1, `rsp_valid_o` 1 cycle after accept. Back-to-back period is 3 cycles.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WORDS x 4-bit adder built from one time-shared
// fulladder4. Operands arrive over a valid/ready request channel and are added
// one nibble per clock, least significant nibble first, with the carry held in
// a register between nibbles. The result leaves over a valid/ready response
// channel.
// Optional feature: define ADDER_SUB_EN to add the sub_i port. With sub_i=1
// the block computes A-B as A+~B+1, and carry_o=0 then signals a borrow.

module fulladder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       carry_i,
    output logic [3:0] sum_o,
    output logic       carry_o
);

    // This is the only adder in the sequencer datapath; every nibble passes through it.
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, carry_i};

endmodule

module nibble_serial_adder_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [4*WORDS-1:0]   a_i,
    input  logic [4*WORDS-1:0]   b_i,
    input  logic                 carry_i,
`ifdef ADDER_SUB_EN
    input  logic                 sub_i,
`endif
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [4*WORDS-1:0]   sum_o,
    output logic                 carry_o,
    output logic                 busy_o
);

    localparam int W     = 4 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     res_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             req_ready_q;
    logic             rsp_valid_q;

    logic [W-1:0]     b_load_d;
    logic             cin_load_d;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       fa_sum_s;
    logic             fa_carry_s;

    // Operand B and carry-in as they are captured at request acceptance.
    always_comb begin
        b_load_d   = b_i;
        cin_load_d = carry_i;
`ifdef ADDER_SUB_EN
        if (sub_i) begin
            b_load_d   = ~b_i;
            cin_load_d = 1'b1;
        end else begin
            b_load_d   = b_i;
            cin_load_d = carry_i;
        end
`endif
    end

    // Select the nibble pair addressed by the current index.
    always_comb begin
        a_nib_s = a_q[{idx_q, 2'b00} +: 4];
        b_nib_s = b_q[{idx_q, 2'b00} +: 4];
    end

    fulladder4 u_fa (
        .a_i     (a_nib_s),
        .b_i     (b_nib_s),
        .carry_i (carry_q),
        .sum_o   (fa_sum_s),
        .carry_o (fa_carry_s)
    );

    // Sequencer: accept operands, ripple one nibble per cycle, then hold the result until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= IDX_ZERO;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        a_q         <= a_i;
                        b_q         <= b_load_d;
                        carry_q     <= cin_load_d;
                        idx_q       <= IDX_ZERO;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end else begin
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_q[{idx_q, 2'b00} +: 4] <= fa_sum_s;
                    carry_q                    <= fa_carry_s;
                    if (idx_q == LAST_IDX) begin
                        // Index parks at zero so it never counts past the last nibble.
                        idx_q       <= IDX_ZERO;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q       <= idx_q + IDX_ONE;
                        state_q     <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) begin
                        // The handshake edge only returns to IDLE; a new request waits one cycle.
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    idx_q       <= IDX_ZERO;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign sum_o       = res_q;
    assign carry_o     = carry_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: a WORDS=4 instance driven
// from a table of hand-computed vectors plus backpressure and mid-RUN reset
// sequences, and a WORDS=1 instance for the single-nibble boundary.

module tb_nibble_serial_adder_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WORDS=4 instance signals
    logic        req_valid, req_ready, cin, rsp_valid, rsp_ready, carry, busy;
    logic [15:0] a, b, sum;
`ifdef ADDER_SUB_EN
    logic        sub;
`endif

    // WORDS=1 instance signals
    logic        req_valid1, req_ready1, cin1, rsp_valid1, rsp_ready1, carry1, busy1;
    logic [3:0]  a1, b1, sum1;
`ifdef ADDER_SUB_EN
    logic        sub1;
`endif

    nibble_serial_adder_ctrl #(.WORDS(4)) u_dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .a_i         (a),
        .b_i         (b),
        .carry_i     (cin),
`ifdef ADDER_SUB_EN
        .sub_i       (sub),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .sum_o       (sum),
        .carry_o     (carry),
        .busy_o      (busy)
    );

    nibble_serial_adder_ctrl #(.WORDS(1)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid1),
        .req_ready_o (req_ready1),
        .a_i         (a1),
        .b_i         (b1),
        .carry_i     (cin1),
`ifdef ADDER_SUB_EN
        .sub_i       (sub1),
`endif
        .rsp_valid_o (rsp_valid1),
        .rsp_ready_i (rsp_ready1),
        .sum_o       (sum1),
        .carry_o     (carry1),
        .busy_o      (busy1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t vecs [9];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the WORDS=4 instance with rsp_ready asserted once valid.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                          output logic [15:0] s, output logic c, output int lat, output logic ctl_ok);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        req_valid = 1'b1;
        a         = av;
        b         = bv;
        cin       = cv;
        tick();
        req_valid = 1'b0;
        a         = ~av;
        b         = 16'h5A5A;
        cin       = ~cv;
        lat       = 0;
        ctl_ok    = 1'b1;
        while (!rsp_valid && lat < 50) begin
            if (req_ready !== 1'b0 || busy !== 1'b1) ctl_ok = 1'b0;
            tick();
            lat++;
        end
        if (req_ready !== 1'b0 || busy !== 1'b1) ctl_ok = 1'b0;
        s         = sum;
        c         = carry;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop_after_hs", 32'(rsp_valid), 32'(1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] s_v;
        logic        c_v;
        int          lat_v;
        logic        ok_v;
        int          n;
        logic        flag;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[8] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1};

        req_valid  = 1'b0; a  = 16'h0000; b  = 16'h0000; cin  = 1'b0; rsp_ready  = 1'b0;
        req_valid1 = 1'b0; a1 = 4'h0;     b1 = 4'h0;     cin1 = 1'b0; rsp_ready1 = 1'b0;
`ifdef ADDER_SUB_EN
        sub  = 1'b0;
        sub1 = 1'b0;
`endif

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(1'b1));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("rst_sum",       32'(sum),       32'(16'h0000));
        chk("rst_carry",     32'(carry),     32'(1'b0));
        chk("rst_busy",      32'(busy),      32'(1'b0));
        chk("rst_w1_ready",  32'(req_ready1), 32'(1'b1));
        chk("rst_w1_busy",   32'(busy1),      32'(1'b0));
        rst_n = 1'b1;
        tick();

        // Table-driven additions
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s_v, c_v, lat_v, ok_v);
            chk($sformatf("vec%0d_sum", i),   32'(s_v),   32'(vecs[i].s));
            chk($sformatf("vec%0d_carry", i), 32'(c_v),   32'(vecs[i].c));
            chk($sformatf("vec%0d_lat", i),   32'(lat_v), 32'(4));
            chk($sformatf("vec%0d_ctl", i),   32'(ok_v),  32'(1'b1));
        end

        // Backpressure: result held for 10 cycles, queued request waits until after handshake
        req_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
        tick();
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_lat", 32'(n), 32'(4));
        flag = 1'b1;
        repeat (10) begin
            if (rsp_valid !== 1'b1 || sum !== 16'h5556 || carry !== 1'b0 || req_ready !== 1'b0) flag = 1'b0;
            tick();
        end
        chk("bp_stable", 32'(flag), 32'(1'b1));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_ready_after_hs", 32'(req_ready), 32'(1'b1));
        chk("bp_idle_after_hs",  32'(busy),      32'(1'b0));
        tick();
        chk("bp_second_accept",  32'(busy),      32'(1'b1));
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp2_sum",   32'(sum),   32'(16'h1010));
        chk("bp2_carry", 32'(carry), 32'(1'b0));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset two cycles into RUN: partial result is discarded
        req_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'(1'b1));
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("mrst_busy",      32'(busy),      32'(1'b0));
        chk("mrst_sum",       32'(sum),       32'(16'h0000));
        chk("mrst_carry",     32'(carry),     32'(1'b0));
        tick();
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (8) begin
            tick();
            if (rsp_valid !== 1'b0) flag = 1'b1;
        end
        chk("mrst_no_rsp", 32'(flag), 32'(1'b0));
        run_op(16'h7FFF, 16'h0001, 1'b0, s_v, c_v, lat_v, ok_v);
        chk("mrst_next_sum",   32'(s_v), 32'(16'h8000));
        chk("mrst_next_carry", 32'(c_v), 32'(1'b0));

`ifdef ADDER_SUB_EN
        // Subtraction: carry_o=0 signals borrow, carry_i ignored
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, s_v, c_v, lat_v, ok_v);
        chk("sub_neg_sum",   32'(s_v), 32'(16'hFFFE));
        chk("sub_neg_carry", 32'(c_v), 32'(1'b0));
        run_op(16'h0007, 16'h0005, 1'b1, s_v, c_v, lat_v, ok_v);
        chk("sub_pos_sum",   32'(s_v), 32'(16'h0002));
        chk("sub_pos_carry", 32'(c_v), 32'(1'b1));
        sub = 1'b0;
`endif

        // WORDS=1: one RUN cycle, back-to-back period of 3 cycles
        req_valid1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; rsp_ready1 = 1'b1;
        tick();
        a1 = 4'h3; b1 = 4'h4; cin1 = 1'b1;
        chk("w1_run_valid",  32'(rsp_valid1), 32'(1'b0));
        chk("w1_run_busy",   32'(busy1),      32'(1'b1));
        tick();
        chk("w1_valid",      32'(rsp_valid1), 32'(1'b1));
        chk("w1_sum",        32'(sum1),       32'(4'h0));
        chk("w1_carry",      32'(carry1),     32'(1'b1));
        chk("w1_done_ready", 32'(req_ready1), 32'(1'b0));
        tick();
        chk("w1_hs_ready",   32'(req_ready1), 32'(1'b1));
        chk("w1_hs_idle",    32'(busy1),      32'(1'b0));
        tick();
        chk("w1_b2b_accept", 32'(busy1),      32'(1'b1));
        req_valid1 = 1'b0;
        tick();
        chk("w1_b2b_valid",  32'(rsp_valid1), 32'(1'b1));
        chk("w1_b2b_sum",    32'(sum1),       32'(4'h8));
        chk("w1_b2b_carry",  32'(carry1),     32'(1'b0));
        tick();
        chk("w1_b2b_drop",   32'(rsp_valid1), 32'(1'b0));
        rsp_ready1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
